// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash controller atoms: one-hot FSM encoding,
// command/address byte limits and ACG command bit positions.
package nfc_pkg;

  localparam logic [5:0] ST_IDLE    = 6'b000001;
  localparam logic [5:0] ST_SETUP   = 6'b000010;
  localparam logic [5:0] ST_WE_LOW  = 6'b000100;
  localparam logic [5:0] ST_WE_HIGH = 6'b001000;
  localparam logic [5:0] ST_HOLD    = 6'b010000;
  localparam logic [5:0] ST_DONE    = 6'b100000;

  localparam int unsigned NFC_CA_MAX_BYTES = 5;

  localparam int unsigned ACG_CAL = 6;
  localparam int unsigned ACG_DOA = 5;

  // A command is always one byte; an address is clamped to 1..NFC_CA_MAX_BYTES.
  function automatic logic [2:0] nfc_ca_byte_count(input logic cas, input logic [15:0] num);
    logic [2:0] n;
    if (cas || num == 16'd0) n = 3'd1;
    else if (num > 16'(NFC_CA_MAX_BYTES)) n = 3'(NFC_CA_MAX_BYTES);
    else n = num[2:0];
    return n;
  endfunction

endpackage

// File: rtl/nfc_atom_cal_if.sv
// Sequencer-facing handshake and NAND bus signals of the command/address latch atom.
interface nfc_atom_cal_if #(
  parameter int unsigned NumberOfWays = 4
) ();

  logic                    iStart;
  logic [NumberOfWays-1:0] iTargetWay;
  logic [15:0]             iNumOfData;
  logic                    iCASelect;
  logic [39:0]             iCAData;
  logic                    oReady;
  logic                    oLastStep;
  logic                    oError;
  logic [NumberOfWays-1:0] oNAND_CEn;
  logic                    oNAND_CLE;
  logic                    oNAND_ALE;
  logic                    oNAND_WEn;
  logic [7:0]              oNAND_DQ;
  logic                    oNAND_DQOE;

  modport master (
    output iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
    input  oReady, oLastStep, oError, oNAND_CEn, oNAND_CLE, oNAND_ALE,
           oNAND_WEn, oNAND_DQ, oNAND_DQOE
  );

  modport slave (
    input  iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
    output oReady, oLastStep, oError, oNAND_CEn, oNAND_CLE, oNAND_ALE,
           oNAND_WEn, oNAND_DQ, oNAND_DQOE
  );

endinterface

// File: rtl/nfc_cycle_timer.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
module nfc_cycle_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] count_o,
  output logic       done_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)              cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  assign count_o = cnt_q;
  assign done_o  = (cnt_q == 4'd0);

endmodule

// File: rtl/nfc_atom_cal.sv
// NAND command/address latch atom: issues one CLE byte or 1..5 ALE bytes per start.
// Optional way check: define NFC_CAL_ONEHOT_CHECK_EN to reject non-one-hot iTargetWay.
module nfc_atom_cal
  import nfc_pkg::*;
#(
  parameter int unsigned NumberOfWays = 4,
  parameter int unsigned SetupCycles  = 2,
  parameter int unsigned WpCycles     = 2,
  parameter int unsigned WhCycles     = 2,
  parameter int unsigned HoldCycles   = 2
) (
  input  logic           iSystemClock,
  input  logic           iReset,
  nfc_atom_cal_if.slave  bus
);

  localparam logic [3:0] SETUP_LD = 4'(SetupCycles - 1);
  localparam logic [3:0] WP_LD    = 4'(WpCycles - 1);
  localparam logic [3:0] WH_LD    = 4'(WhCycles - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HoldCycles - 1);

  logic [5:0]              state_q, state_d;
  logic [NumberOfWays-1:0] way_q, way_d;
  logic                    cas_q, cas_d;
  logic [2:0]              bytes_q, bytes_d;
  logic [39:0]             ca_q, ca_d;
  logic [7:0]              dq_q, dq_d;

  logic                    tmr_load, tmr_done;
  logic [3:0]              tmr_load_val, tmr_count;
  logic                    active_d;

  logic                    ready_q, last_q, cle_q, ale_q, wen_q, dqoe_q;
  logic [NumberOfWays-1:0] cen_q;

  nfc_cycle_timer u_timer (
    .clk_i      (iSystemClock),
    .rst_i      (iReset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .count_o    (tmr_count),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    way_d   = way_q;
    cas_d   = cas_q;
    bytes_d = bytes_q;
    ca_d    = ca_q;
    dq_d    = dq_q;
    case (state_q)
      ST_IDLE: if (bus.iStart) begin
        way_d   = bus.iTargetWay;
        cas_d   = bus.iCASelect;
        bytes_d = nfc_ca_byte_count(bus.iCASelect, bus.iNumOfData);
        ca_d    = {bus.iCAData[31:0], 8'h00};
        dq_d    = bus.iCAData[39:32];
        state_d = ST_SETUP;
`ifdef NFC_CAL_ONEHOT_CHECK_EN
        if (!$onehot(bus.iTargetWay)) begin
          dq_d    = '0;
          state_d = ST_DONE;
        end
`endif
      end
      ST_SETUP: if (tmr_done) state_d = ST_WE_LOW;
      ST_WE_LOW: if (tmr_done) begin
        if (bytes_q > 3'd1) begin
          bytes_d = bytes_q - 3'd1;
          state_d = ST_WE_HIGH;
        end else begin
          bytes_d = '0;
          state_d = ST_HOLD;
        end
      end
      ST_WE_HIGH: begin
        // Next byte lands one cycle after the WEn rise so DQ is stable across it.
        if (tmr_count == WH_LD) begin
          dq_d = ca_q[39:32];
          ca_d = {ca_q[31:0], 8'h00};
        end
        if (tmr_done) state_d = ST_WE_LOW;
      end
      ST_HOLD: if (tmr_done) begin
        dq_d    = '0;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        dq_d    = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_SETUP:   tmr_load_val = SETUP_LD;
      ST_WE_LOW:  tmr_load_val = WP_LD;
      ST_WE_HIGH: tmr_load_val = WH_LD;
      ST_HOLD:    tmr_load_val = HOLD_LD;
      default:    tmr_load_val = '0;
    endcase
  end

  assign active_d = (state_d == ST_SETUP) || (state_d == ST_WE_LOW) ||
                    (state_d == ST_WE_HIGH) || (state_d == ST_HOLD);

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      way_q   <= '0;
      cas_q   <= 1'b0;
      bytes_q <= '0;
      ca_q    <= '0;
      dq_q    <= '0;
      ready_q <= 1'b1;
      last_q  <= 1'b0;
      cen_q   <= '1;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      wen_q   <= 1'b1;
      dqoe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      cas_q   <= cas_d;
      bytes_q <= bytes_d;
      ca_q    <= ca_d;
      dq_q    <= dq_d;
      ready_q <= (state_d == ST_IDLE);
      last_q  <= (state_d == ST_DONE);
      cen_q   <= active_d ? ~way_d : '1;
      cle_q   <= active_d & cas_d;
      ale_q   <= active_d & ~cas_d;
      wen_q   <= (state_d != ST_WE_LOW);
      dqoe_q  <= active_d;
    end
  end

`ifdef NFC_CAL_ONEHOT_CHECK_EN
  logic err_q;
  always_ff @(posedge iSystemClock) begin
    if (iReset) err_q <= 1'b0;
    else        err_q <= (state_q == ST_IDLE) && bus.iStart && !$onehot(bus.iTargetWay);
  end
  assign bus.oError = err_q;
`else
  assign bus.oError = 1'b0;
`endif

  assign bus.oReady     = ready_q;
  assign bus.oLastStep  = last_q;
  assign bus.oNAND_CEn  = cen_q;
  assign bus.oNAND_CLE  = cle_q;
  assign bus.oNAND_ALE  = ale_q;
  assign bus.oNAND_WEn  = wen_q;
  assign bus.oNAND_DQ   = dq_q;
  assign bus.oNAND_DQOE = dqoe_q;

endmodule

// File: doc/nfc_atom_cal.md
# nfc_atom_cal

Command/address latch atom of the NAND flash controller's atomic command generator (ACG). It sits directly downstream of the per-command sequencers (reset, set-feature, read, program), which drive it through ACG command bit 6. For each start it drives one command byte (CLE cycle) or 1–5 address bytes (ALE cycles) onto the NAND bus, then reports completion with a one-cycle last-step pulse.

## Interface
Parameters:
- NumberOfWays, 4, number of chip-enable ways.
- SetupCycles, 2, cycles CEn/CLE/ALE/DQ are valid before the first WEn fall; legal range 1..15.
- WpCycles, 2, WEn low width per byte; legal range 1..15.
- WhCycles, 2, WEn high width between bytes; legal range 2..15.
- HoldCycles, 2, cycles CLE/ALE/DQ are held after the last WEn rise; legal range 1..15.

Ports:
- iSystemClock  in  1  sole clock.
- iReset  in  1  reset; synchronous, active-high.
- iStart  in  1  request; this is ACG command bit 6 from the sequencer.
- iTargetWay  in  NumberOfWays  one-hot way select.
- iNumOfData  in  16  address byte count; ignored for commands.
- iCASelect  in  1  1 = command byte, 0 = address bytes.
- iCAData  in  40  bytes to issue, sent MSB first starting at [39:32].
- oReady  out  1  idle and able to accept a start.
- oLastStep  out  1  one-cycle completion pulse.
- oError  out  1  way-check failure, qualified by oLastStep.
- oNAND_CEn  out  NumberOfWays  active-low chip enables.
- oNAND_CLE  out  1  command latch enable.
- oNAND_ALE  out  1  address latch enable.
- oNAND_WEn  out  1  active-low write enable.
- oNAND_DQ  out  8  data bus.
- oNAND_DQOE  out  1  DQ output enable.

## Operation
- States: IDLE, SETUP, WE_LOW, WE_HIGH, HOLD, DONE.
- Accept: a start is accepted on a rising edge where oReady & iStart. All inputs are captured at that edge. Later input changes are ignored, and iStart is ignored while busy.
- Byte count: if iCASelect=1, exactly 1 byte is sent. Otherwise n = clamp(iNumOfData, 1, 5): 0 is treated as 1, and values above 5 are treated as 5.
- IDLE → SETUP on accept.
- SETUP → WE_LOW after SetupCycles.
- WE_LOW → WE_HIGH after WpCycles if bytes remain; otherwise WE_LOW → HOLD.
- WE_HIGH → WE_LOW after WhCycles.
- HOLD → DONE after HoldCycles.
- DONE → IDLE after 1 cycle.
- In SETUP through HOLD:
  - oNAND_CEn = ~captured way.
  - CLE = captured CASelect; ALE = its inverse.
  - oNAND_DQOE = 1; oNAND_WEn = 0 only in WE_LOW.
- DQ sequencing:
  - DQ is loaded with byte0 on entering SETUP.
  - DQ is held through the first WE_HIGH cycle and loaded with the next byte on the second WE_HIGH cycle.
- In DONE:
  - oLastStep = 1; CEn all 1; CLE, ALE and DQOE are 0.
  - DQ is driven 0 from DONE onward.
- oReady = 1 only in IDLE.
- Reset values (also applied on reset mid-operation, with no oLastStep pulse): oReady=1, oLastStep=0, oError=0, CEn all 1, CLE=0, ALE=0, WEn=1, DQ=0, DQOE=0, state IDLE, byte counter 0.

## Timing
- All outputs are registered.
- Cycle k counts from the accept edge (k=1 is the first cycle after accept).
- oLastStep is high in cycle L = SetupCycles + n·WpCycles + (n−1)·WhCycles + HoldCycles + 1. oReady returns high in cycle L+1.
- With defaults: a command gives L = 7; a 5-byte address gives L = 23.
- Back-to-back: a sequencer that advances its registers on oLastStep presents new data in cycle L+1. It is accepted at the end of L+1, with no idle gap beyond that.
- WEn fall edges are spaced exactly WpCycles + WhCycles apart.
- DQ never changes in the same cycle as a WEn rise.

## Configuration
- NFC_CAL_ONEHOT_CHECK_EN defined:
  - A start whose iTargetWay is not exactly one-hot goes straight from accept to DONE, with no bus activity (CEn stays all 1).
  - In that DONE cycle, oLastStep = 1 and oError = 1.
- Not defined:
  - oError is tied to 0.
  - iTargetWay is used as given; multi-hot broadcasts to several ways, and zero issues with no CE asserted.

## Structure
- Shared package nfc_pkg holds:
  - the state encoding, one-hot, 6 bits;
  - NFC_CA_MAX_BYTES = 5;
  - the ACG bit index constants: CAL = 6, DOA = 5.
- Sub-module nfc_cycle_timer: a loadable 4-bit down-counter with a done flag. One instance is shared by all timed states and reloaded on each state entry.

## Test plan
- Command: iCASelect=1, iCAData=40'hEF_00_00_00_00, way 4'b0001 → CEn=4'b1110, CLE=1, DQ=8'hEF, a single WEn low in cycles 3–4, oLastStep in cycle 7, oReady high in cycle 8.
- Address: iCASelect=0, iNumOfData=5, iCAData=40'h01_02_03_04_05 → DQ sequence 01,02,03,04,05, five WEn pulses 4 cycles apart, ALE=1, oLastStep in cycle 23.
- Clamp: iNumOfData=0 → 1 byte; iNumOfData=9 → 5 bytes; iStart pulsed mid-operation → ignored, exactly one oLastStep.
- Reset in cycle 4 of an address operation → next cycle all outputs equal their reset values, no oLastStep, and a fresh start is accepted.
- Back-to-back: a sequencer model issues command EFh then address 01h → second accept in cycle 8; second oLastStep 7 cycles later.
- NFC_CAL_ONEHOT_CHECK_EN with way 4'b0011 → oLastStep=1 and oError=1 in cycle 1, CEn stays 4'b1111.
